smd_pad_poller: RTL



---
 rtl/smd_pad_pkg.sv | 41 ++++
 rtl/smd_pad_sync.sv | 27 ++
 rtl/smd_pad_poller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/smd_pad_pkg.sv
// Shared definitions for the Mega Drive pad poller: button bit positions,
// phase count, FSM states and the final button-masking helper.
package smd_pad_pkg;

   localparam int N_PHASES = 8;

   localparam int UP = 0;
   localparam int DW = 1;
   localparam int LF = 2;
   localparam int RG = 3;
   localparam int A  = 4;
   localparam int B  = 5;
   localparam int C  = 6;
   localparam int ST = 7;
   localparam int Z  = 8;
   localparam int Y  = 9;
   localparam int X  = 10;
   localparam int MD = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PHASE = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Extended buttons only mean something on a six-button pad; no pad means no buttons.
   function automatic logic [11:0] mask_buttons(input logic present,
                                                input logic six,
                                                input logic [11:0] raw);
      logic [11:0] r;
      r = raw;
      if (!six) begin
         r[MD:Z] = 4'b0000;
      end
      if (!present) begin
         r = '0;
      end
      return r;
   endfunction

endpackage

// File: rtl/smd_pad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low pad return pins.
// Resets to all-ones so an idle (released) line is seen during reset.
module smd_pad_sync #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/smd_pad_poller.sv
// Mega Drive / Genesis controller port poller: drives SEL through the 8-phase
// six-button read, decodes 12 buttons plus pad presence/type, strobes valid.
module smd_pad_poller
   import smd_pad_pkg::*;
#(
   parameter int PHASE_CYCLES = 20,
   parameter int GAP_CYCLES   = 10000,
   parameter int FRAME_CYCLES = 166667
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        poll_req,
   input  logic [5:0]  p_in,
   output logic        sel,
   output logic [11:0] buttons,
   output logic        six_button,
   output logic        pad_present,
   output logic        valid,
   output logic        busy
);

   localparam int PW = $clog2(PHASE_CYCLES);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int FW = $clog2(FRAME_CYCLES);

   logic [5:0]    s;
   state_e        state_q;
   logic [2:0]    k_q;
   logic [PW-1:0] pcnt_q;
   logic [GW-1:0] gap_q;
   logic [FW-1:0] frame_q, frame_d;
   logic          pending_q, pending_d;
   logic          sel_q, valid_q, busy_q, six_q, present_q;
   logic [11:0]   buttons_q;
   logic          sh_present_q, sh_six_q;
   logic [11:0]   sh_btn_q;
   logic          auto_hit, gap_ok, start_poll, phase_last, last_phase;

   smd_pad_sync #(.W(6)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (p_in),
      .q_o   (s)
   );

   assign auto_hit   = enable && (frame_q == FW'(FRAME_CYCLES - 1));
   assign gap_ok     = (gap_q == GW'(GAP_CYCLES));
   assign start_poll = (state_q == IDLE) && gap_ok && (pending_q || poll_req || auto_hit);
   assign phase_last = (pcnt_q == PW'(PHASE_CYCLES - 1));
   assign last_phase = (k_q == 3'(N_PHASES - 1));

   // Frame counter saturates so a late auto trigger is held, not lost.
   always_comb begin
      frame_d   = frame_q;
      pending_d = pending_q | poll_req;
      if (start_poll) begin
         frame_d   = '0;
         pending_d = 1'b0;
      end else if (frame_q != FW'(FRAME_CYCLES - 1)) begin
         frame_d = frame_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         frame_q   <= frame_d;
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         k_q          <= '0;
         pcnt_q       <= '0;
         gap_q        <= GW'(GAP_CYCLES);
         sel_q        <= 1'b1;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         six_q        <= 1'b0;
         present_q    <= 1'b0;
         buttons_q    <= '0;
         sh_present_q <= 1'b0;
         sh_six_q     <= 1'b0;
         sh_btn_q     <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               sel_q <= 1'b1;
               if (!gap_ok) begin
                  gap_q <= gap_q + 1'b1;
               end
               if (start_poll) begin
                  state_q <= PHASE;
                  k_q     <= '0;
                  pcnt_q  <= '0;
                  sel_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end

            PHASE: begin
               if (phase_last) begin
                  pcnt_q <= '0;
                  // Return pins are sampled at the very end of each phase so the pad has settled.
                  case (k_q)
                     3'd0: begin
                        sh_present_q <= (s[3:2] == 2'b00);
                        sh_btn_q[A]  <= ~s[1];
                        sh_btn_q[ST] <= ~s[0];
                     end
                     3'd1: begin
                        sh_btn_q[UP] <= ~s[5];
                        sh_btn_q[DW] <= ~s[4];
                        sh_btn_q[LF] <= ~s[3];
                        sh_btn_q[RG] <= ~s[2];
                        sh_btn_q[B]  <= ~s[1];
                        sh_btn_q[C]  <= ~s[0];
                     end
                     3'd4: begin
                        sh_six_q <= (s[5:2] == 4'b0000);
                     end
                     3'd5: begin
                        sh_btn_q[Z]  <= ~s[5];
                        sh_btn_q[Y]  <= ~s[4];
                        sh_btn_q[X]  <= ~s[3];
                        sh_btn_q[MD] <= ~s[2];
                     end
                     default: ;
                  endcase
                  if (last_phase) begin
                     state_q   <= DONE;
                     sel_q     <= 1'b1;
                     valid_q   <= 1'b1;
                     present_q <= sh_present_q;
                     six_q     <= sh_present_q & sh_six_q;
                     buttons_q <= mask_buttons(sh_present_q, sh_six_q, sh_btn_q);
                  end else begin
                     k_q   <= k_q + 3'd1;
                     sel_q <= ~k_q[0];
                  end
               end else begin
                  pcnt_q <= pcnt_q + 1'b1;
               end
            end

            DONE: begin
               state_q <= IDLE;
               gap_q   <= '0;
               busy_q  <= 1'b0;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign sel         = sel_q;
   assign buttons     = buttons_q;
   assign six_button  = six_q;
   assign pad_present = present_q;
   assign valid       = valid_q;
   assign busy        = busy_q;

endmodule
